// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants and types for the seven-segment digit feeder
package seg_disp_pkg;

    localparam int NUM_DIGITS = 8;

    typedef logic [4:0] digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    localparam digit_t DIG_BLANK = 5'h10;
    localparam digit_t DIG_DASH  = 5'h11;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;

    // Entry n sits at bits [8n+7:8n]; listed F down to 0.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg_digit_feeder_if.sv
// rtl/seg_digit_feeder_if.sv - load/status bundle between value source and digit feeder
interface seg_digit_feeder_if;

    logic        load;
    logic [31:0] data;
    logic        dec_mode;
    logic [7:0]  dp_mask;
    logic        busy;
    logic        ovf;

    modport master (
        output load, data, dec_mode, dp_mask,
        input  busy, ovf
    );

    modport slave (
        input  load, data, dec_mode, dp_mask,
        output busy, ovf
    );

endinterface

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - 5-bit digit code to active-low {g,f,e,d,c,b,a}
module hex_to_seg7
    import seg_disp_pkg::*;
(
    input  digit_t     code,
    output logic [6:0] seg7
);

    always_comb begin
        seg7 = SEG_BLANK[6:0];
        if (code[4]) begin
            // Unused special codes fall back to blank.
            if (code == DIG_DASH) seg7 = SEG_DASH[6:0];
        end else begin
            seg7 = SEG_HEX[code[3:0]][6:0];
        end
    end

endmodule

// File: rtl/seg_digit_feeder.sv
// rtl/seg_digit_feeder.sv - hex/decimal value to committed 8-digit display, scanned segment output
module seg_digit_feeder
    import seg_disp_pkg::*;
#(
    parameter bit BLANK_LZ      = 1'b1,
    parameter bit DP_ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    seg_digit_feeder_if.slave   bus,
    input  logic [2:0]          which,
    output logic [7:0]          seg
);

    state_t                       state, next_state;
    logic [31:0]                  bin;
    logic [39:0]                  bcd;
    logic [39:0]                  bcd_adj;
    logic [4:0]                   cnt;
    logic [7:0]                   dp_pend;
    logic [7:0]                   dp_commit;
    logic                         ovf_q;
    digit_t [NUM_DIGITS-1:0]      disp;
    digit_t [NUM_DIGITS-1:0]      commit_dig;
    logic                         bcd_ovf;
    logic                         leading;
    logic [2:0]                   idx;
    logic [6:0]                   seg7;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.load && bus.dec_mode) next_state = CONV;
            CONV:    if (cnt == 5'd31)             next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Blank from the top down until the first nonzero digit; digit 0 always shows.
    always_comb begin
        leading    = BLANK_LZ;
        commit_dig = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && bcd[4*i +: 4] == 4'd0) begin
                commit_dig[i] = DIG_BLANK;
            end else begin
                leading       = 1'b0;
                commit_dig[i] = {1'b0, bcd[4*i +: 4]};
            end
        end
        commit_dig[0] = {1'b0, bcd[3:0]};
    end

    assign bcd_ovf = |bcd[39:32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            dp_pend   <= '0;
            dp_commit <= '0;
            ovf_q     <= 1'b0;
            disp      <= {NUM_DIGITS{DIG_BLANK}};
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        if (!bus.dec_mode) begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                disp[i] <= {1'b0, bus.data[4*i +: 4]};
                            end
                            dp_commit <= bus.dp_mask;
                            ovf_q     <= 1'b0;
                        end else begin
                            bin     <= bus.data;
                            bcd     <= '0;
                            cnt     <= '0;
                            dp_pend <= bus.dp_mask;
                        end
                    end
                end
                CONV: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    cnt        <= cnt + 5'd1;
                end
                COMMIT: begin
                    if (bcd_ovf) begin
                        disp  <= {NUM_DIGITS{DIG_DASH}};
                        ovf_q <= 1'b1;
                    end else begin
                        disp  <= commit_dig;
                        ovf_q <= 1'b0;
                    end
                    dp_commit <= dp_pend;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.ovf  = ovf_q;

    // The scanner moves `which` on negedge, so the output path stays unregistered.
    assign idx = 3'd7 - which;

    hex_to_seg7 u_hex_to_seg7 (
        .code (disp[idx]),
        .seg7 (seg7)
    );

    assign seg = {(DP_ACTIVE_LOW ? ~dp_commit[idx] : dp_commit[idx]), seg7};

endmodule

// File: tb/tb_seg_digit_feeder.sv
// tb/tb_seg_digit_feeder.sv - scoreboard bench for seg_digit_feeder
module tb_seg_digit_feeder;

    logic        clk;
    logic        rst_n;
    logic [2:0]  which;
    logic [7:0]  seg;

    int vectors;
    int miscompares;
    int n;

    logic [7:0] exp_q[$];
    logic [7:0] tbl [16];

    seg_digit_feeder_if bus ();

    seg_digit_feeder #(.BLANK_LZ(1'b1), .DP_ACTIVE_LOW(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .which (which),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_seg(input logic [31:0] v, input bit dec,
                                             input logic [7:0] mask, input int w);
        int d;
        logic [7:0] s;
        logic [31:0] p;
        d = 7 - w;
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        if (!dec)                s = tbl[(v >> (4*d)) & 32'hF];
        else if (v > 99_999_999) s = 8'hBF;
        else if (d > 0 && v < p) s = 8'hFF;
        else                     s = tbl[(v / p) % 10];
        s[7] = ~mask[d];
        return s;
    endfunction

    task automatic push_expect(input logic [31:0] v, input bit dec, input logic [7:0] mask);
        for (int w = 0; w < 8; w++) exp_q.push_back(model_seg(v, dec, mask, w));
    endtask

    task automatic push_blank();
        for (int w = 0; w < 8; w++) exp_q.push_back(8'hFF);
    endtask

    task automatic sweep();
        for (int w = 0; w < 8; w++) begin
            which = 3'(w);
            #1;
            if (exp_q.size() == 0) chk($sformatf("sb_empty_w%0d", w), 32'd1, 32'd0);
            else                   chk($sformatf("seg_w%0d", w), {24'd0, seg}, {24'd0, exp_q.pop_front()});
        end
    endtask

    task automatic do_load(input logic [31:0] v, input bit dec, input logic [7:0] mask);
        bus.data     = v;
        bus.dec_mode = dec;
        bus.dp_mask  = mask;
        bus.load     = 1'b1;
        @(posedge clk); #1;
        bus.load     = 1'b0;
    endtask

    // Counts cycles with busy high; optionally pokes a competing load at cycle poke_at.
    task automatic wait_idle(input int poke_at, output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            if (cycles == poke_at) begin
                bus.data     = 32'd7;
                bus.dec_mode = 1'b1;
                bus.dp_mask  = 8'hFF;
                bus.load     = 1'b1;
            end
            @(posedge clk); #1;
            bus.load = 1'b0;
            cycles++;
        end
        if (cycles >= 100) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic dec_case(input logic [31:0] v, input logic [7:0] mask, input int poke_at);
        do_load(v, 1'b1, mask);
        push_expect(v, 1'b1, mask);
        chk("busy_after_load", {31'd0, bus.busy}, 32'd1);
        wait_idle(poke_at, n);
        chk("busy_cycles", n, 32'd33);
        chk("ovf", {31'd0, bus.ovf}, {31'd0, v > 99_999_999});
        sweep();
    endtask

    initial begin
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vectors = 0;
        miscompares = 0;
        which = 3'd0;
        bus.load = 1'b0;
        bus.data = '0;
        bus.dec_mode = 1'b0;
        bus.dp_mask = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        push_blank();
        sweep();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_load(32'h1234_ABCD, 1'b0, 8'h00);
        push_expect(32'h1234_ABCD, 1'b0, 8'h00);
        chk("hex_busy", {31'd0, bus.busy}, 32'd0);
        sweep();

        dec_case(32'd12345678, 8'h04, -1);
        dec_case(32'd42, 8'h00, -1);
        dec_case(32'd0, 8'h00, -1);
        dec_case(32'hFFFF_FFFF, 8'h00, -1);

        do_load(32'h0, 1'b0, 8'h00);
        push_expect(32'h0, 1'b0, 8'h00);
        chk("hex_ovf_clr", {31'd0, bus.ovf}, 32'd0);
        sweep();

        dec_case(32'd98765, 8'h81, 3);

        do_load(32'd12345678, 1'b1, 8'h00);
        repeat (10) begin @(posedge clk); #1; end
        chk("conv_busy", {31'd0, bus.busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        push_blank();
        sweep();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", {31'd0, bus.busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seg_digit_feeder.md
Name: seg_digit_feeder

Overview:
- Upstream feeder for the 8-digit scanned seven-segment display.
- Accepts a 32-bit value with a load strobe and converts it to eight digit codes:
  - hex mode: direct nibbles;
  - decimal mode: iterative double-dabble binary-to-BCD.
- Holds the eight digit codes in a committed display register.
- Drives the segment pattern for whichever digit the scanner currently selects via `which`.
- Sits between the ALU result or debug mux and the scan driver.

Parameters:
- BLANK_LZ, 1, when 1, leading zero digits are blanked in decimal mode. The least-significant digit is never blanked.
- DP_ACTIVE_LOW, 1, polarity of seg[7]; 1 means a lit dp drives 0.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  one-cycle strobe; samples data, dec_mode and dp_mask when accepted.
- data  input  32  unsigned value to display.
- dec_mode  input  1  1 = decimal, 0 = hexadecimal.
- dp_mask  input  8  decimal-point enables; bit i belongs to digit i, where digit 0 is rightmost.
- which  input  3  digit currently selected by the scanner; 0 = leftmost (digit 7), 7 = rightmost (digit 0).
- seg  output  8  active-low segment pattern {dp,g,f,e,d,c,b,a} for the selected digit.
- busy  output  1  high while a decimal conversion is in progress.
- ovf  output  1  high when the committed decimal value exceeded 99_999_999.

Behaviour:
- Reset, asynchronous, rst_n low:
  - state = IDLE, busy = 0, ovf = 0;
  - all 8 committed digit codes = BLANK and committed dp_mask = 0, so seg = 8'hFF for every `which`;
  - the conversion shift register is cleared.
- Digit code is 5 bits:
  - {special, nibble};
  - special=1 with nibble 0 = BLANK (8'hFF);
  - special=1 with nibble 1 = DASH (8'hBF).
- Segment map (active low, dp off): 0 C0, 1 F9, 2 A4, 3 B0, 4 99, 5 92, 6 82, 7 F8, 8 80, 9 90, A 88, b 83, C C6, d A1, E 86, F 8E.
- seg output:
  - combinational from the committed digit at index (7-which);
  - seg[7] = ~dp_mask[7-which] when DP_ACTIVE_LOW;
  - follows `which` with no register stage, because the scanner changes `which` on negedge.
- State IDLE:
  - load=1 and dec_mode=0: in the same edge, commit the 8 nibbles of data as digit codes, latch dp_mask, clear ovf. Stay in IDLE, so latency is 1 cycle.
  - load=1 and dec_mode=1: latch data into a 32-bit shift register, clear the 40-bit BCD accumulator, clear the iteration counter, latch dp_mask into a pending register, go to CONV, busy=1.
- State CONV, 32 cycles, counter 0..31:
  - each cycle, add 3 to every BCD nibble that is ≥5, then shift {bcd,bin} left by 1;
  - after the counter reaches 31, go to COMMIT.
- State COMMIT, 1 cycle:
  - if BCD digits 9..8 are nonzero: ovf=1 and all digits = DASH;
  - otherwise ovf=0 and digits 7..0 = BCD digits 7..0, with leading-zero blanking when BLANK_LZ;
  - dp_mask is committed; return to IDLE; busy=0.
- Decimal latency: 34 clocks from load acceptance to the new seg pattern. busy is high for exactly 33 cycles.
- The committed display is unchanged during CONV, so there is no flicker mid-conversion.
- load while busy=1 is ignored; no queueing.
- Reset mid-conversion aborts the conversion and the display blanks.
- data = 0 in decimal mode shows a single "0" at digit 0.
- Width rule: the BCD accumulator is 40 bits (10 digits) so that 32'hFFFF_FFFF converts without loss before the overflow check.

Decomposition:
- Shared package `seg_disp_pkg`:
  - the 8-bit segment constants for 0-F, BLANK and DASH;
  - the 5-bit digit code typedef;
  - the state enum IDLE/CONV/COMMIT;
  - the digit count constant, 8.
- One combinational sub-module, `hex_to_seg7`, maps a 5-bit digit code to 7 active-low segment bits.
- Double-dabble and control stay in the top.

Test Plan:
- Reset, then sweep which 0..7 -> seg=8'hFF for every position; busy=0, ovf=0.
- Hex load data=32'h1234_ABCD, dp_mask=0 -> on the next cycle which=0..7 gives C0^... i.e. F9,A4,B0,99,88,83,C6,A1.
- Decimal load data=12345678, dp_mask=8'h04 -> busy high for 33 cycles; after commit, which=0..7 gives F9,A4,B0,99,92,82,F8,80; which=5 gives 8'h02 (dp lit on digit 2).
- Decimal load data=42 with BLANK_LZ=1 -> which 0..5 = FF, which 6 = 99, which 7 = A4. Decimal load data=0 -> only which 7 = C0.
- Decimal load data=32'hFFFF_FFFF -> ovf=1 and all positions 8'hBF. A following hex load of 0 -> ovf=0 and all positions C0.
- Second load during CONV is ignored; original result appears at cycle 34. Deassert rst_n at cycle 10 of CONV -> asynchronous blank (all FF), busy=0 immediately.
